dbg_pkt_engine: RTL
===================

Name: dbg_pkt_engine

Overview:
- Parametrised debug packet engine for the NES emulator.
- Consumes command bytes from a show-ahead UART rx FIFO and drives one of NUM_CH byte-wide memory channels (CPU, PPU, ...).
- Returns read data and status over the UART tx FIFO.
- Adds channel selection, variable address width, a fill command and an error-query command. The UART itself sits outside this block.

Parameters:
ADDR_W, 16, memory address width in bits (8..24); address bytes in packet AB = ceil(ADDR_W/8), LSB first
NUM_CH, 2, number of memory channels (1..8)
RD_LATENCY, 1, cycles from address/select valid to mem_rd_data valid (1..4)

Ports:
clk  in  1  system clock
rst  in  1  reset
rx_data  in  8  head byte of UART rx FIFO (valid when rx_empty=0)
rx_empty  in  1  rx FIFO empty
rd_en  out  1  pop rx FIFO (combinational; asserted only when rx_empty=0)
parity_err  in  1  UART parity error pulse
tx_data  out  8  byte to UART tx FIFO (registered)
wr_en  out  1  push tx FIFO (registered, 1-cycle pulse)
tx_full  in  1  tx FIFO full
mem_a  out  ADDR_W  shared memory address (registered)
mem_sel  out  NUM_CH  one-hot channel select; all-zero when idle
mem_r_nw  out  1  1=read, 0=write strobe (1 cycle per byte)
mem_wr_data  out  8  write data
mem_rd_data  in  8*NUM_CH  per-channel read data, channel c at [8c+7:8c]
mem_err  in  NUM_CH  per-channel invalid-request pulse

Interface decisions: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values: state=DECODE, err=0, mem_a=0, mem_sel=0, mem_r_nw=1, wr_en=0, tx_data=0, rd_en=0.
- A reset asserted mid-packet abandons the packet and discards any pending read data.
- Opcodes:
  - 00 ECHO: OP, CNT_LO, CNT_HI, CNT data bytes.
  - 01 MEM_RD: OP, CH, AB addr bytes, CNT_LO, CNT_HI.
  - 02 MEM_WR: as MEM_RD, then CNT data bytes.
  - 03 FILL: as MEM_RD, then 1 data byte.
  - 04 ERR_QUERY: OP only.
- Error register, 4 sticky bits: [0] parity, [1] unknown opcode, [2] mem_err (any channel), [3] bad channel (CH>=NUM_CH). Set wins over a same-cycle clear.
- States: DECODE, HDR, ECHO, RD_WAIT, RD_SEND, WR, FILL_DATA, FILL_WR, ERR_SEND.
- DECODE: on !rx_empty, pop the opcode. Go to HDR, ECHO header (reuse HDR with ECHO layout) or ERR_SEND. An unknown opcode sets err[1] and stays in DECODE.
- HDR: one byte popped per cycle when !rx_empty; header fields are latched. After CNT_HI:
  - CNT==0 -> DECODE.
  - Otherwise -> RD_WAIT, WR, FILL_DATA or ECHO.
  - CNT is 16 bits; 0xFFFF is the maximum transfer.
- ECHO: each popped byte is pushed to tx the next cycle. It pops only when !rx_empty && !tx_full; CNT is decremented per byte.
- RD_WAIT: mem_sel/mem_a are held and mem_r_nw=1 for RD_LATENCY cycles. The selected byte is then captured and the state moves to RD_SEND.
- RD_SEND: when !tx_full, push the captured byte, mem_a+=1, CNT-=1. If CNT reaches 0 -> DECODE, else -> RD_WAIT.
- Sustained read throughput is 1 byte per RD_LATENCY+1 cycles.
- WR: per byte, on !rx_empty pop it, drive mem_wr_data=byte, mem_r_nw=0 and the mem_sel pulse for 1 cycle, then mem_a+=1 and CNT-=1. At 0 -> DECODE.
- FILL: pop 1 byte, then issue CNT write strobes on consecutive cycles with incrementing mem_a. No rx stall is possible once the byte is held.
- Address arithmetic wraps modulo 2^ADDR_W (e.g. 0xFFFF+1 -> 0x0000 at ADDR_W=16).
- Bad channel: sets err[3] and the packet is fully consumed with no mem_sel asserted. RD returns CNT bytes of 0x00, WR/FILL data is discarded, so the host protocol never desyncs.
- ERR_SEND: when !tx_full, push {4'b0, err} and clear err in the same cycle, then -> DECODE.
- parity_err and any mem_err bit are ORed into err in every state.

Decomposition:
- Shared package dbg_pkg: opcode constants, err bit positions, state encoding, and the AB computation function.
- One natural sub-module, dbg_hdr_collect: the header byte shifter/counter producing ch, addr and cnt, plus a done pulse.

Test Plan:
- ECHO: rx 00 03 00 AA BB CC -> tx AA, BB, CC in order. The engine stalls while tx_full=1 and no byte is lost.
- MEM_RD: CH=1, addr 0x0200, CNT=2, RD_LATENCY=2, channel1 model returns 0x11/0x22 -> tx 11, 22; mem_sel=2'b10 throughout; mem_a 0x0200 then 0x0201.
- MEM_WR wrap: CH=0, addr 0xFFFF, CNT=2, data 5A A5 -> writes 0x5A@FFFF and 0xA5@0000; mem_sel=0 between strobes.
- FILL: CH=0, addr 0x0010, CNT=4, data 77 -> 4 consecutive write strobes at 0x10..0x13, then DECODE.
- Errors: opcode 09, then MEM_RD with CH=5 CNT=1, then 04 -> tx 00 (zero fill), then 0x0A; a second 04 -> tx 00.
- Reset mid-MEM_WR after 1 of 3 bytes -> all outputs at reset values next cycle; the following ECHO packet works.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug packet engine: opcodes, error bits, FSM states.
// Pure declarations; no timing or flow control of its own.
package dbg_pkg;

    localparam logic [7:0] OP_ECHO      = 8'h00;
    localparam logic [7:0] OP_MEM_RD    = 8'h01;
    localparam logic [7:0] OP_MEM_WR    = 8'h02;
    localparam logic [7:0] OP_FILL      = 8'h03;
    localparam logic [7:0] OP_ERR_QUERY = 8'h04;

    localparam int ERR_PARITY = 0;
    localparam int ERR_OPCODE = 1;
    localparam int ERR_MEM    = 2;
    localparam int ERR_CHAN   = 3;

    typedef enum logic [3:0] {
        ST_DECODE,
        ST_HDR,
        ST_ECHO,
        ST_RD_WAIT,
        ST_RD_SEND,
        ST_WR,
        ST_FILL_DATA,
        ST_FILL_WR,
        ST_ERR_SEND
    } state_t;

    function automatic int addr_bytes(input int addr_w);
        return (addr_w + 7) / 8;
    endfunction

endpackage

// File: rtl/dbg_hdr_collect.sv
// Header byte collector: latches CH, LSB-first address and 16-bit count; done pulses one cycle after the last byte.
// Consumes a byte only when take is high, so rx backpressure is handled entirely by the caller.
module dbg_hdr_collect
    import dbg_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              echo,
    input  logic              take,
    input  logic [7:0]        dat,
    output logic              busy,
    output logic              done,
    output logic [7:0]        ch,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       cnt
);

    localparam int AB = addr_bytes(ADDR_W);
    localparam logic [2:0] POS_LO = 3'(AB + 1);
    localparam logic [2:0] POS_HI = 3'(AB + 2);

    logic [2:0]      pos;
    logic [8*AB-1:0] abuf;

    // ECHO headers carry only the count, so they start at the count position.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            pos  <= 3'd0;
            ch   <= 8'h00;
            abuf <= '0;
            cnt  <= 16'h0000;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                pos  <= echo ? POS_LO : 3'd0;
            end else if (busy && take) begin
                pos <= pos + 3'd1;
                if (pos == 3'd0)
                    ch <= dat;
                for (int k = 0; k < AB; k++)
                    if (pos == 3'(k + 1))
                        abuf[8*k +: 8] <= dat;
                if (pos == POS_LO)
                    cnt[7:0] <= dat;
                if (pos == POS_HI) begin
                    cnt[15:8] <= dat;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
            end
        end
    end

    assign addr = abuf[ADDR_W-1:0];

endmodule

// File: rtl/dbg_pkt_engine.sv
// Debug packet engine: decodes rx command bytes into multi-channel memory reads/writes, echo and error query.
// Reads take RD_LATENCY+1 cycles per byte; stalls on rx_empty for input and on tx_full before any tx push.
module dbg_pkt_engine
    import dbg_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int NUM_CH     = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_empty,
    output logic                rd_en,
    input  logic                parity_err,
    output logic [7:0]          tx_data,
    output logic                wr_en,
    input  logic                tx_full,
    output logic [ADDR_W-1:0]   mem_a,
    output logic [NUM_CH-1:0]   mem_sel,
    output logic                mem_r_nw,
    output logic [7:0]          mem_wr_data,
    input  logic [8*NUM_CH-1:0] mem_rd_data,
    input  logic [NUM_CH-1:0]   mem_err
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    state_t state, state_nxt;
    logic [3:0]  err, err_set;
    logic [7:0]  op_q;
    logic [15:0] cnt;
    logic [1:0]  lat;
    logic [7:0]  rd_byte, sel_byte, tx_byte;
    logic        strobe_q, strobe_now, tx_push, err_clr, cnt_dec;
    logic        rd_capture, rd_advance, hdr_load;
    logic        hdr_start, hdr_echo, hdr_take, hdr_busy, hdr_done;
    logic [7:0]  hdr_ch;
    logic [ADDR_W-1:0] hdr_addr;
    logic [15:0] hdr_cnt;
    logic [NUM_CH-1:0] onehot;
    logic        ch_ok;

    dbg_hdr_collect #(.ADDR_W(ADDR_W)) u_hdr (
        .clk   (clk),
        .rst   (rst),
        .start (hdr_start),
        .echo  (hdr_echo),
        .take  (hdr_take),
        .dat   (rx_data),
        .busy  (hdr_busy),
        .done  (hdr_done),
        .ch    (hdr_ch),
        .addr  (hdr_addr),
        .cnt   (hdr_cnt)
    );

    // An out-of-range channel yields no select and reads back as zero.
    always_comb begin
        onehot   = '0;
        sel_byte = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            onehot[c] = (hdr_ch == 8'(c));
            if (hdr_ch == 8'(c))
                sel_byte = mem_rd_data[8*c +: 8];
        end
    end

    assign ch_ok    = |onehot;
    assign hdr_take = rd_en && (state == ST_HDR);

    always_comb begin
        state_nxt  = state;
        rd_en      = 1'b0;
        hdr_start  = 1'b0;
        hdr_echo   = 1'b0;
        hdr_load   = 1'b0;
        strobe_now = 1'b0;
        tx_push    = 1'b0;
        tx_byte    = rd_byte;
        err_clr    = 1'b0;
        cnt_dec    = 1'b0;
        rd_capture = 1'b0;
        rd_advance = 1'b0;
        err_set             = 4'b0000;
        err_set[ERR_PARITY] = parity_err;
        err_set[ERR_MEM]    = |mem_err;

        case (state)
            ST_DECODE: begin
                if (!rx_empty) begin
                    rd_en = 1'b1;
                    case (rx_data)
                        OP_ECHO: begin
                            hdr_start = 1'b1;
                            hdr_echo  = 1'b1;
                            state_nxt = ST_HDR;
                        end
                        OP_MEM_RD, OP_MEM_WR, OP_FILL: begin
                            hdr_start = 1'b1;
                            state_nxt = ST_HDR;
                        end
                        OP_ERR_QUERY: state_nxt = ST_ERR_SEND;
                        default:      err_set[ERR_OPCODE] = 1'b1;
                    endcase
                end
            end
            ST_HDR: begin
                rd_en = hdr_busy && !rx_empty;
                if (hdr_done) begin
                    hdr_load = 1'b1;
                    if (op_q != OP_ECHO && !ch_ok)
                        err_set[ERR_CHAN] = 1'b1;
                    if (hdr_cnt == 16'h0000)
                        state_nxt = ST_DECODE;
                    else begin
                        case (op_q)
                            OP_ECHO:   state_nxt = ST_ECHO;
                            OP_MEM_RD: state_nxt = ST_RD_WAIT;
                            OP_MEM_WR: state_nxt = ST_WR;
                            default:   state_nxt = ST_FILL_DATA;
                        endcase
                    end
                end
            end
            ST_ECHO: begin
                if (!rx_empty && !tx_full) begin
                    rd_en   = 1'b1;
                    tx_push = 1'b1;
                    tx_byte = rx_data;
                    cnt_dec = 1'b1;
                    if (cnt == 16'h0001)
                        state_nxt = ST_DECODE;
                end
            end
            ST_RD_WAIT: begin
                if (lat == LAT_LAST) begin
                    rd_capture = 1'b1;
                    state_nxt  = ST_RD_SEND;
                end
            end
            ST_RD_SEND: begin
                if (!tx_full) begin
                    tx_push    = 1'b1;
                    cnt_dec    = 1'b1;
                    rd_advance = 1'b1;
                    state_nxt  = (cnt == 16'h0001) ? ST_DECODE : ST_RD_WAIT;
                end
            end
            ST_WR: begin
                if (!rx_empty) begin
                    rd_en      = 1'b1;
                    strobe_now = 1'b1;
                    cnt_dec    = 1'b1;
                    if (cnt == 16'h0001)
                        state_nxt = ST_DECODE;
                end
            end
            ST_FILL_DATA: begin
                if (!rx_empty) begin
                    rd_en     = 1'b1;
                    state_nxt = ST_FILL_WR;
                end
            end
            ST_FILL_WR: begin
                strobe_now = 1'b1;
                cnt_dec    = 1'b1;
                if (cnt == 16'h0001)
                    state_nxt = ST_DECODE;
            end
            ST_ERR_SEND: begin
                if (!tx_full) begin
                    tx_push   = 1'b1;
                    tx_byte   = {4'b0000, err};
                    err_clr   = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            default: state_nxt = ST_DECODE;
        endcase

        if (rst)
            rd_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_DECODE;
            err         <= 4'b0000;
            op_q        <= 8'h00;
            cnt         <= 16'h0000;
            lat         <= 2'd0;
            rd_byte     <= 8'h00;
            strobe_q    <= 1'b0;
            mem_a       <= '0;
            mem_sel     <= '0;
            mem_r_nw    <= 1'b1;
            mem_wr_data <= 8'h00;
            wr_en       <= 1'b0;
            tx_data     <= 8'h00;
        end else begin
            state <= state_nxt;
            err   <= (err_clr ? 4'b0000 : err) | err_set;
            wr_en <= tx_push;
            if (tx_push)
                tx_data <= tx_byte;
            if (hdr_start)
                op_q <= rx_data;
            if (hdr_load)
                cnt <= hdr_cnt;
            else if (cnt_dec)
                cnt <= cnt - 16'd1;
            lat <= (state == ST_RD_WAIT && !rd_capture) ? lat + 2'd1 : 2'd0;
            if (rd_capture)
                rd_byte <= sel_byte;
            if (rd_en && (state == ST_WR || state == ST_FILL_DATA))
                mem_wr_data <= rx_data;
            strobe_q <= strobe_now;
            mem_r_nw <= !(strobe_now && ch_ok);
            mem_sel  <= (ch_ok && (strobe_now || state_nxt == ST_RD_WAIT || state_nxt == ST_RD_SEND))
                        ? onehot : '0;
            // The address steps after a write strobe has been seen, or after a read byte leaves.
            if (hdr_load && op_q != OP_ECHO)
                mem_a <= hdr_addr;
            else if (strobe_q || rd_advance)
                mem_a <= mem_a + ADDR_W'(1);
        end
    end

endmodule
